// File: rtl/ri_core_pkg.sv
// Shared constants and types for the multi-cycle R/I-type core.
package ri_core_pkg;

  localparam logic [6:0] OP_R = 7'b0110011;
  localparam logic [6:0] OP_I = 7'b0010011;

  localparam logic [2:0] F3_ADD  = 3'b000;
  localparam logic [2:0] F3_SLL  = 3'b001;
  localparam logic [2:0] F3_SLT  = 3'b010;
  localparam logic [2:0] F3_SLTU = 3'b011;
  localparam logic [2:0] F3_XOR  = 3'b100;
  localparam logic [2:0] F3_SR   = 3'b101;
  localparam logic [2:0] F3_OR   = 3'b110;
  localparam logic [2:0] F3_AND  = 3'b111;

  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;

  typedef enum logic [3:0] {
    ALU_ADD, ALU_SUB, ALU_SLL, ALU_SLT, ALU_SLTU,
    ALU_XOR, ALU_SRL, ALU_SRA, ALU_OR, ALU_AND
  } alu_op_t;

  typedef enum logic [2:0] {
    FETCH, DECODE, EXECUTE, WRITEBACK, HALT
  } state_t;

endpackage

// File: rtl/alu_ri.sv
// Combinational XLEN-wide ALU for the R/I-type instruction set.
module alu_ri
  import ri_core_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  alu_op_t         op,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  output logic [XLEN-1:0] y
);

  localparam int SHW = $clog2(XLEN);

  logic [SHW-1:0] shamt;
  assign shamt = b[SHW-1:0];

  // Result select; shifts use only the low log2(XLEN) bits of b.
  always_comb begin
    // NOTE: every path assigns y via this default, so no latch can be inferred.
    y = '0;
    case (op)
      ALU_ADD:  y = a + b;
      ALU_SUB:  y = a - b;
      ALU_SLL:  y = a << shamt;
      ALU_SLT:  y = {{(XLEN-1){1'b0}}, ($signed(a) < $signed(b))};
      ALU_SLTU: y = {{(XLEN-1){1'b0}}, (a < b)};
      ALU_XOR:  y = a ^ b;
      ALU_SRL:  y = a >> shamt;
      ALU_SRA:  y = $unsigned($signed(a) >>> shamt);
      ALU_OR:   y = a | b;
      ALU_AND:  y = a & b;
      default:  y = '0;
    endcase
  end

endmodule

// File: rtl/ri_multicycle_core.sv
// Multi-cycle R/I-type core: FETCH -> DECODE -> EXECUTE -> WRITEBACK,
// with illegal encodings trapped into a sticky HALT state.
module ri_multicycle_core
  import ri_core_pkg::*;
#(
  parameter int              XLEN     = 32,
  parameter int              NREGS    = 32,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            reset,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_valid,
  input  logic [31:0]     imem_rdata,
  output logic [XLEN-1:0] pc,
  output logic [XLEN-1:0] alu_out,
  output logic            wb_we,
  output logic [4:0]      wb_addr,
  output logic [XLEN-1:0] wb_data,
  output logic            retire,
  output logic            illegal,
  output logic            halted
);

  localparam int         SHW     = $clog2(XLEN);
  localparam int         RW      = $clog2(NREGS);
  localparam logic [5:0] NREGS_L = 6'(NREGS);

  state_t          state_q, state_d;
  logic [31:0]     ir_q;
  logic [XLEN-1:0] pc_q, alu_out_q;
  logic [XLEN-1:0] op_a_q, op_b_q;
  alu_op_t         alu_op_q;
  logic [4:0]      rd_q;
  logic            illegal_q;
  logic [XLEN-1:0] regs_q [NREGS];
  logic [XLEN-1:0] alu_y;

  // Instruction fields.
  logic [6:0]  opcode, funct7;
  logic [2:0]  funct3;
  logic [4:0]  rd, rs1, rs2;
  logic [11:0] imm_raw;
  assign opcode  = ir_q[6:0];
  assign rd      = ir_q[11:7];
  assign funct3  = ir_q[14:12];
  assign rs1     = ir_q[19:15];
  assign rs2     = ir_q[24:20];
  assign funct7  = ir_q[31:25];
  assign imm_raw = ir_q[31:20];

  logic [XLEN-1:0] imm_ext, rs1_val, rs2_val;
  assign imm_ext = {{(XLEN-12){imm_raw[11]}}, imm_raw};
  assign rs1_val = (rs1 == 5'd0) ? '0 : regs_q[rs1[RW-1:0]];
  assign rs2_val = (rs2 == 5'd0) ? '0 : regs_q[rs2[RW-1:0]];

  // Immediate bits above the shift amount must be zero; bit 30 (imm[10])
  // is checked separately because it selects SRAI.
  logic shift_hi_ok;
  assign shift_hi_ok = (((imm_raw & 12'hBFF) >> SHW) == 12'd0);

  logic    dec_enc_ok, dec_regs_ok, dec_legal, dec_use_imm;
  alu_op_t dec_op;

  // Instruction decode: ALU operation, operand source and legality.
  always_comb begin
    dec_enc_ok  = 1'b0;
    dec_use_imm = 1'b0;
    dec_op      = ALU_ADD;
    case (opcode)
      OP_R: begin
        case (funct3)
          F3_ADD: begin
            dec_op     = (funct7 == F7_ALT) ? ALU_SUB : ALU_ADD;
            dec_enc_ok = (funct7 == F7_BASE) || (funct7 == F7_ALT);
          end
          F3_SR: begin
            dec_op     = (funct7 == F7_ALT) ? ALU_SRA : ALU_SRL;
            dec_enc_ok = (funct7 == F7_BASE) || (funct7 == F7_ALT);
          end
          F3_SLL:  begin dec_op = ALU_SLL;  dec_enc_ok = (funct7 == F7_BASE); end
          F3_SLT:  begin dec_op = ALU_SLT;  dec_enc_ok = (funct7 == F7_BASE); end
          F3_SLTU: begin dec_op = ALU_SLTU; dec_enc_ok = (funct7 == F7_BASE); end
          F3_XOR:  begin dec_op = ALU_XOR;  dec_enc_ok = (funct7 == F7_BASE); end
          F3_OR:   begin dec_op = ALU_OR;   dec_enc_ok = (funct7 == F7_BASE); end
          F3_AND:  begin dec_op = ALU_AND;  dec_enc_ok = (funct7 == F7_BASE); end
          default: dec_enc_ok = 1'b0;
        endcase
      end
      OP_I: begin
        dec_use_imm = 1'b1;
        dec_enc_ok  = 1'b1;
        case (funct3)
          F3_ADD:  dec_op = ALU_ADD;
          F3_SLT:  dec_op = ALU_SLT;
          F3_SLTU: dec_op = ALU_SLTU;
          F3_XOR:  dec_op = ALU_XOR;
          F3_OR:   dec_op = ALU_OR;
          F3_AND:  dec_op = ALU_AND;
          F3_SLL: begin
            dec_op     = ALU_SLL;
            dec_enc_ok = shift_hi_ok && !imm_raw[10];
          end
          F3_SR: begin
            dec_op     = imm_raw[10] ? ALU_SRA : ALU_SRL;
            dec_enc_ok = shift_hi_ok;
          end
          default: dec_enc_ok = 1'b0;
        endcase
      end
      default: dec_enc_ok = 1'b0;
    endcase

    // rs2 only exists as a register index in R-type encodings.
    dec_regs_ok = ({1'b0, rd} < NREGS_L) && ({1'b0, rs1} < NREGS_L) &&
                  (dec_use_imm || ({1'b0, rs2} < NREGS_L));
    dec_legal   = dec_enc_ok && dec_regs_ok;
  end

  alu_ri #(.XLEN(XLEN)) u_alu (
    .op (alu_op_q),
    .a  (op_a_q),
    .b  (op_b_q),
    .y  (alu_y)
  );

  // FSM state register.
  always_ff @(posedge clk) begin
    // NOTE: state is updated with non-blocking assignments so every flop
    // samples pre-edge values and simulation matches the synthesized logic.
    if (reset) state_q <= FETCH;
    else       state_q <= state_d;
  end

  // FSM next state and per-phase outputs.
  always_comb begin
    state_d  = state_q;
    imem_req = 1'b0;
    retire   = 1'b0;
    wb_we    = 1'b0;
    wb_addr  = '0;
    wb_data  = '0;
    halted   = 1'b0;
    case (state_q)
      FETCH: begin
        imem_req = 1'b1;
        if (imem_valid) state_d = DECODE;
      end
      DECODE:  state_d = dec_legal ? EXECUTE : HALT;
      EXECUTE: state_d = WRITEBACK;
      WRITEBACK: begin
        retire  = 1'b1;
        wb_we   = (rd_q != 5'd0);
        wb_addr = rd_q;
        wb_data = alu_out_q;
        state_d = FETCH;
      end
      HALT: begin
        halted  = 1'b1;
        state_d = HALT;
      end
      default: state_d = FETCH;
    endcase
  end

  // Datapath registers: instruction, operands, ALU result, PC, trap flag.
  // op_b holds the sign-extended immediate for I-type instructions.
  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q      <= RESET_PC;
      alu_out_q <= '0;
      ir_q      <= '0;
      op_a_q    <= '0;
      op_b_q    <= '0;
      alu_op_q  <= ALU_ADD;
      rd_q      <= '0;
      illegal_q <= 1'b0;
    end else begin
      case (state_q)
        FETCH:     if (imem_valid) ir_q <= imem_rdata;
        DECODE: begin
          if (dec_legal) begin
            op_a_q   <= rs1_val;
            op_b_q   <= dec_use_imm ? imm_ext : rs2_val;
            alu_op_q <= dec_op;
            rd_q     <= rd;
          end else begin
            illegal_q <= 1'b1;
          end
        end
        EXECUTE:   alu_out_q <= alu_y;
        WRITEBACK: pc_q <= pc_q + {{(XLEN-3){1'b0}}, 3'd4};
        default:   ;
      endcase
    end
  end

  // Register file: two read ports (above), one write port in WRITEBACK.
  always_ff @(posedge clk) begin
    if (reset) begin
      // NOTE: the register file is cleared on reset, which forces it into
      // flops rather than a RAM macro; this core requires all-zero registers.
      for (int i = 0; i < NREGS; i++) regs_q[i] <= '0;
    end else if (state_q == WRITEBACK && rd_q != 5'd0) begin
      regs_q[rd_q[RW-1:0]] <= alu_out_q;
    end
  end

  assign pc        = pc_q;
  assign imem_addr = pc_q;
  assign alu_out   = alu_out_q;
  assign illegal   = illegal_q;

endmodule

// File: doc/ri_multicycle_core.md
# ri_multicycle_core

Parametrised multi-cycle successor to the single-cycle R/I-type datapath: it fetches one 32-bit instruction at a time over a valid-handshaked instruction-memory port, then decodes, executes and writes back using an internal register file and ALU. The PC is owned internally, and an FSM sequences the four phases. Illegal encodings are trapped into a sticky halt state. It is the core of the R/I-type processor top level, with instruction memory outside the block.

## Interface
Parameters:
- XLEN, 32: datapath, PC and register width; legal values 32 or 64.
- NREGS, 32: register count; legal values 16 or 32. x0 is hard-wired to zero.
- RESET_PC, 0: PC value loaded on reset; XLEN bits, word aligned.

Ports:
- clk  in  1  single clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high reset.
- imem_req  out  1  fetch request; high only in FETCH.
- imem_addr  out  XLEN  byte address of the fetch; always equals pc.
- imem_valid  in  1  imem_rdata is valid this cycle.
- imem_rdata  in  32  instruction word.
- pc  out  XLEN  address of the current instruction.
- alu_out  out  XLEN  registered ALU result of the last EXECUTE.
- wb_we  out  1  one-cycle pulse during a register write.
- wb_addr  out  5  destination register index.
- wb_data  out  XLEN  data being written.
- retire  out  1  one-cycle pulse per completed instruction.
- illegal  out  1  sticky; set when an illegal instruction is decoded.
- halted  out  1  sticky; the core is in HALT.

## Operation
- Supported R-type instructions (opcode 0110011): ADD, SUB, SLL, SLT, SLTU, XOR, SRL, SRA, OR, AND. funct7 must be 0000000, or 0100000 for SUB and SRA only.
- Supported I-type instructions (opcode 0010011): ADDI, SLTI, SLTIU, XORI, ORI, ANDI, SLLI, SRLI, SRAI.
  - The 12-bit immediate is sign-extended to XLEN.
  - Shift amount is the low log2(XLEN) bits of the immediate.
  - Shift upper bits must be zero, except bit 30, which is allowed for SRAI only.
- Arithmetic wraps modulo 2^XLEN. SLT/SLTI compare signed; SLTU/SLTIU compare unsigned.
- An instruction is illegal if any of the following holds:
  - any opcode, funct3 or funct7 combination other than those listed above;
  - any of rd, rs1 or rs2 is >= NREGS.
- FSM states and transitions:
  - FETCH: hold imem_req high until imem_valid is sampled high, then capture the instruction register and go to DECODE.
  - DECODE: latch operand A, operand B and the immediate. Go to EXECUTE, or to HALT if illegal.
  - EXECUTE: register the ALU result into alu_out.
  - WRITEBACK: write rd unless rd = 0; pulse retire; pc <= pc + 4, wrapping modulo 2^XLEN; go to FETCH.
  - HALT: absorbing; only reset exits it. Set illegal and halted. pc stays at the faulting instruction.
- A write to x0 is suppressed: wb_we stays 0, but retire still pulses.
- Reads of x0 return 0.
- Reset mid-operation abandons the in-flight instruction with no register write and no retire.

## Timing
- Reset values:
  - pc = RESET_PC, alu_out = 0.
  - wb_we, wb_addr, wb_data, retire, illegal and halted all 0.
  - All registers 0; state = FETCH.
- imem_req is high in the first cycle after reset deasserts.
- A zero-wait fetch is allowed: if imem_valid is high in the same cycle imem_req first rises, the instruction is captured on that edge.
- Latency:
  - With zero wait states, one instruction completes every 4 cycles.
  - Each cycle of imem_valid low in FETCH adds one cycle.
- imem_valid is ignored outside FETCH. imem_addr is stable while imem_req is high.
- retire, wb_we, wb_addr and wb_data are asserted together, in the WRITEBACK cycle only.
- A register written in WRITEBACK is visible to the next instruction's DECODE, so no bypass is needed.

## Structure
- Package ri_core_pkg holds:
  - opcode constants (OP_R, OP_I);
  - funct3/funct7 constants;
  - alu_op_t enum;
  - state_t enum (FETCH, DECODE, EXECUTE, WRITEBACK, HALT).
- Sub-module alu_ri is a combinational XLEN-wide ALU driven by alu_op_t.
- The register file is internal: one write port, two read ports.

## Test plan
- Zero-wait fetch with ADDI x1, x0, 5 at RESET_PC=0:
  - retire on cycle 4, wb_addr=1, wb_data=5;
  - pc becomes 4.
- Sequence ADDI x2, x0, -1, then SRAI x3, x2, 4, then SRLI x4, x2, 28 (XLEN=32):
  - x3 = 0xFFFFFFFF;
  - x4 = 0x0000000F.
- SLT vs SLTU with x5 = -1 and x6 = 1:
  - SLT x7, x5, x6 writes 1;
  - SLTU x8, x5, x6 writes 0.
- imem_valid held low for 3 cycles in FETCH:
  - imem_req and imem_addr stay stable throughout;
  - retire arrives 7 cycles after fetch start.
- ADD x0, x1, x1: wb_we=0, retire=1, x0 still reads 0.
- Illegal cases:
  - opcode 0x7F: illegal=1 and halted=1 persist, pc unchanged.
  - NREGS=16 with rd=17: same response.
  - Reset then restarts fetch at RESET_PC.
